// File: rtl/mode_seq_ctrl_pkg.sv
// seq_types_pkg: shared types for the mode sequencer.
//   cmd_t   : command encoding carried on the command handshake
//   state_t : sequencer state, also exported on the status port
//   DIR_UP / DIR_DOWN : encoding of cmd_dir
package seq_types_pkg;

  typedef enum logic [1:0] {CMD_NOP, CMD_START, CMD_STOP, CMD_PAUSE} cmd_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mode_seq_ctrl_if.sv
// mode_seq_ctrl_if: command handshake between a control FSM (master) and
// the sequencer (slave).
//   cmd_valid : command present (master -> slave)
//   cmd_ready : command accepted on cmd_valid && cmd_ready (slave -> master)
//   cmd       : CMD_NOP / CMD_START / CMD_STOP / CMD_PAUSE
//   cmd_len   : job length, WIDTH bits
//   cmd_dir   : 0 = count up, 1 = count down
interface mode_seq_ctrl_if #(
  parameter int WIDTH = 8
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  seq_types_pkg::cmd_t  cmd;
  logic [WIDTH-1:0]     cmd_len;
  logic                 cmd_dir;

  modport master (
    output cmd_valid, cmd, cmd_len, cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd, cmd_len, cmd_dir,
    output cmd_ready
  );

endinterface

// File: rtl/mode_seq_ctrl_step_counter.sv
// seq_step_counter: WIDTH-bit up/down step counter for one sequencer job.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture load_len/load_dir and set the first step value
//   load_len  : job length L
//   load_dir  : DIR_UP / DIR_DOWN
//   en        : take one step in the captured direction
//   clr       : force the step value to 0 (abort)
//   count     : current step index
//   last      : count holds the final step of the job
module seq_step_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_len,
  input  logic             load_dir,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             last
);
  import seq_types_pkg::*;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [WIDTH-1:0] len_q;
  logic             dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      len_q <= '0;
      dir_q <= DIR_UP;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      len_q <= load_len;
      dir_q <= load_dir;
      // A zero-length job must leave the index at 0 in either direction.
      if (load_len == '0 || load_dir == DIR_UP)
        count <= '0;
      else
        count <= load_len - STEP;
    end else if (en) begin
      if (dir_q == DIR_DOWN)
        count <= count - STEP;
      else
        count <= count + STEP;
    end
  end

  assign last = (dir_q == DIR_DOWN) ? (count == '0) : (count == len_q - STEP);

endmodule

// File: rtl/mode_seq_ctrl.sv
// mode_seq_ctrl: command-driven sequencer running an up/down count of
// programmable length and reporting state plus a done pulse.
//   clk, rst   : clock, synchronous active-high reset
//   cmd_bus    : command handshake (slave side of mode_seq_ctrl_if)
//   out        : current step index
//   state      : IDLE / RUN / PAUSE / DONE
//   busy       : state is RUN or PAUSE
//   done       : high exactly while state is DONE
//   jobs_done  : completed-job counter, only when SEQ_STATUS_CNT_EN is defined
//
// state | meaning
// IDLE  | waiting for START; out holds the last job's final value
// RUN   | stepping out once per cycle until the last step
// PAUSE | out frozen; START resumes, STOP aborts
// DONE  | one-cycle completion pulse; commands not accepted
module mode_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mode_seq_ctrl_if.slave        cmd_bus,
  output logic [WIDTH-1:0]      out,
  output seq_types_pkg::state_t state,
  output logic                  busy,
  output logic                  done
`ifdef SEQ_STATUS_CNT_EN
  ,
  output logic [CNT_W-1:0]      jobs_done
`endif
);
  import seq_types_pkg::*;

  state_t state_q, state_d;
  logic   cmd_acc;
  logic   cnt_load, cnt_en, cnt_clr, cnt_last;

  assign cmd_bus.cmd_ready = (state_q != DONE);
  assign cmd_acc           = cmd_bus.cmd_valid && cmd_bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_acc && cmd_bus.cmd == CMD_START) begin
          cnt_load = 1'b1;
          state_d  = (cmd_bus.cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cmd_acc && cmd_bus.cmd == CMD_STOP) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else begin
          // The step at a PAUSE edge is still taken; at the last step the
          // counter holds, and a PAUSE there defers the DONE until resume.
          cnt_en = !cnt_last;
          if (cmd_acc && cmd_bus.cmd == CMD_PAUSE) state_d = PAUSE;
          else if (cnt_last)                       state_d = DONE;
        end
      end
      PAUSE: begin
        if (cmd_acc && cmd_bus.cmd == CMD_STOP) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (cmd_acc && cmd_bus.cmd == CMD_START) begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seq_step_counter #(.WIDTH(WIDTH)) u_step (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_len (cmd_bus.cmd_len),
    .load_dir (cmd_bus.cmd_dir),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .count    (out),
    .last     (cnt_last)
  );

  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = (state_q == DONE);

`ifdef SEQ_STATUS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)       jobs_done <= '0;
    else if (done) jobs_done <= jobs_done + CNT_W'(1);
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mode_seq_ctrl.sv
module tb_mode_seq_ctrl;
  import seq_types_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] out;
  state_t           state;
  logic             busy;
  logic             done;
`ifdef SEQ_STATUS_CNT_EN
  logic [CNT_W-1:0] jobs_done;
`endif

  int errors = 0;
  int checks = 0;

  mode_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mode_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_bus   (bus),
    .out       (out),
    .state     (state),
    .busy      (busy),
    .done      (done)
`ifdef SEQ_STATUS_CNT_EN
    ,
    .jobs_done (jobs_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one edge, then return to NOP.
  task automatic send(input cmd_t c, input logic [WIDTH-1:0] len, input logic dir);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.cmd_len   = len;
    bus.cmd_dir   = dir;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.cmd_len   = '0;
    bus.cmd_dir   = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.cmd_len   = '0;
    bus.cmd_dir   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_state", state, IDLE);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    tick();
`ifdef SEQ_STATUS_CNT_EN
    chk("rst_jobs", jobs_done, 0);
`endif

    // L=5 up: out 0..4, DONE, IDLE, out holds 4
    send(CMD_START, 8'd5, DIR_UP);
    chk("up5_state0", state, RUN);
    chk("up5_out0", out, 0);
    chk("up5_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("up5_out", out, k);
      chk("up5_run", state, RUN);
    end
    tick();
    chk("up5_done_state", state, DONE);
    chk("up5_done", done, 1);
    chk("up5_done_out", out, 4);
    chk("up5_done_ready", bus.cmd_ready, 0);
    chk("up5_done_busy", busy, 0);
    tick();
    chk("up5_idle", state, IDLE);
    chk("up5_idle_done", done, 0);
    chk("up5_idle_out", out, 4);
    tick();
    chk("up5_hold_out", out, 4);

    // L=3 down: out 2,1,0 then DONE
    send(CMD_START, 8'd3, DIR_DOWN);
    chk("dn3_out2", out, 2);
    chk("dn3_ready_run", bus.cmd_ready, 1);
    tick();
    chk("dn3_out1", out, 1);
    tick();
    chk("dn3_out0", out, 0);
    chk("dn3_not_done", done, 0);
    tick();
    chk("dn3_done", done, 1);
    chk("dn3_ready_done", bus.cmd_ready, 0);
    chk("dn3_done_out", out, 0);
    tick();
    chk("dn3_idle", state, IDLE);
    chk("dn3_ready_idle", bus.cmd_ready, 1);

    // L=0: DONE immediately, busy never high
    send(CMD_START, 8'd0, DIR_DOWN);
    chk("l0_state", state, DONE);
    chk("l0_done", done, 1);
    chk("l0_out", out, 0);
    chk("l0_busy", busy, 0);
    tick();
    chk("l0_idle", state, IDLE);
    chk("l0_done_low", done, 0);
    chk("l0_busy_idle", busy, 0);

    // L=10 up, PAUSE at out=3, hold, resume with ignored len/dir
    send(CMD_START, 8'd10, DIR_UP);
    tick();
    tick();
    chk("pz_out2", out, 2);
    send(CMD_PAUSE, 8'd0, 1'b0);
    chk("pz_state", state, PAUSE);
    chk("pz_out3", out, 3);
    chk("pz_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pz_hold_out", out, 3);
      chk("pz_hold_state", state, PAUSE);
    end
    send(CMD_START, 8'd99, DIR_DOWN);
    chk("pz_resume_state", state, RUN);
    chk("pz_resume_out", out, 3);
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk("pz_resume_cnt", out, k);
    end
    tick();
    chk("pz_done", done, 1);
    chk("pz_done_out", out, 9);
    tick();
    chk("pz_idle", state, IDLE);
`ifdef SEQ_STATUS_CNT_EN
    chk("jobs_after4", jobs_done, 4);
`endif

    // L=10 up, START mid-run ignored, STOP at out=6
    send(CMD_START, 8'd10, DIR_UP);
    tick();
    send(CMD_START, 8'd3, DIR_DOWN);
    chk("restart_ignored_out", out, 2);
    chk("restart_ignored_state", state, RUN);
    for (int k = 3; k <= 6; k++) tick();
    chk("stop_out6", out, 6);
    send(CMD_STOP, 8'd0, 1'b0);
    chk("stop_state", state, IDLE);
    chk("stop_out", out, 0);
    chk("stop_done", done, 0);
    chk("stop_busy", busy, 0);
    tick();
    chk("stop_no_pulse", done, 0);
`ifdef SEQ_STATUS_CNT_EN
    chk("stop_jobs", jobs_done, 4);
`endif

    // PAUSE on the last step: hold, resume, then DONE one cycle later
    send(CMD_START, 8'd2, DIR_UP);
    tick();
    chk("last_out1", out, 1);
    send(CMD_PAUSE, 8'd0, 1'b0);
    chk("last_pause_state", state, PAUSE);
    chk("last_pause_out", out, 1);
    send(CMD_START, 8'd0, 1'b0);
    chk("last_resume_state", state, RUN);
    chk("last_resume_out", out, 1);
    tick();
    chk("last_done", done, 1);
    chk("last_done_out", out, 1);
    tick();

    // STOP from PAUSE
    send(CMD_START, 8'd6, DIR_DOWN);
    chk("pstop_out5", out, 5);
    send(CMD_PAUSE, 8'd0, 1'b0);
    chk("pstop_paused_out", out, 4);
    send(CMD_STOP, 8'd0, 1'b0);
    chk("pstop_state", state, IDLE);
    chk("pstop_out", out, 0);

    // Maximum length up: last value 2^WIDTH-2
    send(CMD_START, 8'd255, DIR_UP);
    chk("max_out0", out, 0);
    repeat (254) tick();
    chk("max_last_out", out, 254);
    chk("max_last_state", state, RUN);
    tick();
    chk("max_done", done, 1);
    chk("max_done_out", out, 254);
    tick();

    // Reset mid-RUN at out=7, then PAUSE in IDLE is ignored
    send(CMD_START, 8'd20, DIR_UP);
    repeat (7) tick();
    chk("mrst_out7", out, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_state", state, IDLE);
    chk("mrst_out", out, 0);
    chk("mrst_busy", busy, 0);
`ifdef SEQ_STATUS_CNT_EN
    chk("mrst_jobs", jobs_done, 0);
`endif
    chk("idle_pause_ready", bus.cmd_ready, 1);
    send(CMD_PAUSE, 8'd0, 1'b0);
    chk("idle_pause_state", state, IDLE);
    chk("idle_pause_out", out, 0);
    tick();
    chk("idle_pause_state2", state, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
